ps2_keyboard_tx: RTL and testbench

//  Device-side PS/2 keyboard emulator. Serialises scancode bytes into 11-bit PS/2 frames on ps2_clk/ps2_data.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_tx_fifo.sv | 68 ++++++
 rtl/ps2_keyboard_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 keyboard transmitter and the PS/2 host receiver.
//   ps2_state_e    transmitter FSM states (IDLE, SHIFT, GAP)
//   PS2_FRAME_BITS bits per frame: start, eight data bits LSB first, parity, stop
//   PS2_START      level of the start bit
//   PS2_STOP       level of the stop bit
//   ps2_parity()   odd-parity bit for one data byte
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic        PS2_START      = 1'b0;
  localparam logic        PS2_STOP       = 1'b1;

  // Makes the total count of ones across the data bits and the parity bit odd.
  function automatic logic ps2_parity(input logic [7:0] data_byte);
    return ~^data_byte;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: small synchronous FIFO that queues scancode bytes ahead of the transmitter.
// The transmitter instantiates it only when PS2_TX_FIFO_EN is defined.
//   clk      in   system clock
//   reset    in   synchronous reset, active high; empties the queue
//   push     in   write wr_data; ignored while full
//   wr_data  in   byte to enqueue
//   pop      in   drop the head entry; ignored while empty
//   rd_data  out  head entry, valid while empty=0
//   full     out  no free entry
//   empty    out  no stored entry
// DEPTH must be a power of two so the pointers wrap on their own.
module ps2_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A push and a pop in the same cycle leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: device-side PS/2 keyboard emulator. Scancode bytes arriving on a valid/ready
// handshake are serialised into 11-bit PS/2 frames. The block generates ps2_clk itself and backs
// off while the host inhibits the bus.
//   clk       in   system clock
//   reset     in   synchronous reset, active high
//   tx_data   in   scancode byte to send
//   tx_valid  in   tx_data valid
//   tx_ready  out  byte accepted at this edge if tx_valid (queue not full)
//   inhibit   in   host holding the clock line low
//   ps2_clk   out  generated PS/2 clock, idles high
//   ps2_data  out  PS/2 data, idles high
//   busy      out  frame in progress or inter-frame gap running
//   tx_done   out  one-cycle pulse after a frame completes normally
// Build option PS2_TX_FIFO_EN: adds a FIFO_DEPTH-entry byte queue. Without it, a single holding
// register keeps tx_ready low from accept until that frame's tx_done.
//
// state | meaning
// IDLE  | lines high, waiting for a queued byte while inhibit is low
// SHIFT | clocking out frame bit bit_cnt; div_cnt sweeps the high then the low phase
// GAP   | lines high for IDLE_GAP cycles after a completed or aborted frame
module ps2_keyboard_tx #(
  parameter int unsigned HALF_PER   = 20,
  parameter int unsigned IDLE_GAP   = 40,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done
);

  import ps2_pkg::*;

  localparam int unsigned DIV_W = $clog2(2 * HALF_PER);
  localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_PER - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_PER);
  localparam logic [3:0]       BIT_LAST = 4'(PS2_FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP - 1);

  if (HALF_PER < 4) begin : g_bad_half_per
    $error("HALF_PER must be at least 4");
  end
  if (IDLE_GAP < 1) begin : g_bad_idle_gap
    $error("IDLE_GAP must be at least 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  ps2_state_e       state;
  ps2_state_e       next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [7:0]       head_data;
  logic             q_full;
  logic             q_empty;
  logic             push;
  logic             pop;

  logic             launch;
  logic             last_bit;
  logic             frame_done;
  logic             abort;
  logic             gap_done;
  logic [15:0]      frame_bits;

  assign tx_ready = ~q_full;
  assign push     = tx_valid & tx_ready;
  assign pop      = frame_done;

  assign launch     = ~q_empty & ~inhibit;
  assign last_bit   = (bit_cnt == BIT_LAST);
  assign frame_done = (state == SHIFT) && last_bit && (div_cnt == DIV_LAST);
  // Once the stop bit is on the wire the frame is allowed to finish.
  assign abort      = (state == SHIFT) && inhibit && !last_bit;
  assign gap_done   = (gap_cnt == '0);

  // Padded with ones above the stop bit so any 4-bit index stays in range.
  assign frame_bits = {5'b11111, PS2_STOP, ps2_parity(head_data), head_data, PS2_START};

`ifdef PS2_TX_FIFO_EN
  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (tx_data),
    .pop     (pop),
    .rd_data (head_data),
    .full    (q_full),
    .empty   (q_empty)
  );
`else
  logic hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      head_data  <= 8'h00;
    end else if (push) begin
      hold_valid <= 1'b1;
      head_data  <= tx_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign q_full  = hold_valid;
  assign q_empty = ~hold_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // When the gap expires with a byte already waiting, the next frame starts directly, so
  // consecutive frames are separated by exactly IDLE_GAP high cycles.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (launch) next_state = SHIFT;
      end
      SHIFT: begin
        if (abort || frame_done) next_state = GAP;
      end
      GAP: begin
        if (gap_done) next_state = launch ? SHIFT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= 4'd0;
      gap_cnt <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= frame_done;

      if (next_state == SHIFT && state != SHIFT) begin
        div_cnt <= '0;
        bit_cnt <= 4'd0;
      end else if (state == SHIFT) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (!last_bit) bit_cnt <= bit_cnt + 4'd1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      if (next_state == GAP && state != GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && !gap_done) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  always_comb begin
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    busy     = (state != IDLE);
    if (state == SHIFT) begin
      ps2_clk  = (div_cnt < DIV_HALF);
      ps2_data = frame_bits[bit_cnt];
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx: drives ps2_keyboard_tx with directed and random scancodes, decodes the
// PS/2 lines on falling ps2_clk and compares decoded bytes, frame bits and timing against a
// byte-queue reference model.
module tb_ps2_keyboard_tx;

  localparam int HALF_PER = 4;
  localparam int IDLE_GAP = 8;
  localparam int FRAME_CYC = 11 * 2 * HALF_PER;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       tx_done;

  ps2_keyboard_tx #(
    .HALF_PER   (HALF_PER),
    .IDLE_GAP   (IDLE_GAP),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .inhibit  (inhibit),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: bytes accepted and not yet seen on the wire, in order.
  int exp_q[$];

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return {1'b1, ((ones % 2) == 0), b, 1'b0};
  endfunction

  // Line decoder, sampling on the falling system edge.
  logic [10:0] rx_frame;
  logic [10:0] last_frame;
  logic        prev_clk;
  int nbits = 0, hi_run = 0, both_run = 0, rx_cnt = 0, done_cnt = 0;
  int gap_q[$];
  int done_cyc_q[$];

  always @(negedge clk) begin
    int exp_b;
    if (reset) begin
      nbits    = 0;
      hi_run   = 0;
      both_run = 0;
      prev_clk = 1'b1;
    end else begin
      if (tx_done) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
      end
      if (ps2_clk && !ps2_data && nbits == 0 && both_run > 0) gap_q.push_back(both_run);
      if (prev_clk && !ps2_clk) begin
        // A high stretch longer than one phase means any earlier partial frame was abandoned.
        if (hi_run > HALF_PER) nbits = 0;
        rx_frame[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          last_frame = rx_frame;
          rx_cnt++;
          exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          check("rx_byte", int'(rx_frame[8:1]), exp_b);
          check("rx_frame_bits", int'(rx_frame), int'(frame_of(rx_frame[8:1])));
        end
      end
      hi_run   = ps2_clk ? hi_run + 1 : 0;
      both_run = (ps2_clk && ps2_data) ? both_run + 1 : 0;
      prev_clk = ps2_clk;
    end
  end

  task automatic send_one(input logic [7:0] b, output int start_cyc);
    check("acc_ready", int'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(int'(b));
    #1;
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("start_latency", int'(ps2_data), 0);
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int done_at);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("tx_done_timeout", 0, 1);
    done_at = cyc;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy && exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, rx_base, done_base, n_acc, g;
    bit r;
    int acc_cyc [3];
    logic [7:0] burst [3];
    logic [7:0] rb [8];

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    inhibit  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ps2_clk", int'(ps2_clk), 1);
    check("rst_ps2_data", int'(ps2_data), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_done", int'(tx_done), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_tx_ready", int'(tx_ready), 1);

    // 1: 0x1C, timing and exact frame
    rx_base = rx_cnt;
    send_one(8'h1C, s);
    wait_done(200, d);
    check("t1_done_latency", d - s, FRAME_CYC);
    check("t1_frame", int'(last_frame), 'h438);
    check("t1_rx_count", rx_cnt - rx_base, 1);
    @(posedge clk);
    #1;
    check("t1_done_pulse", int'(tx_done), 0);
    wait_idle(100);

    // 2: 0xF0, parity bit set
    rx_base = rx_cnt;
    send_one(8'hF0, s);
    wait_done(200, d);
    check("t2_frame", int'(last_frame), 'h7E0);
    check("t2_rx_count", rx_cnt - rx_base, 1);
    wait_idle(100);

    // 3: burst with tx_valid held high
    burst[0] = 8'h1C; burst[1] = 8'hF0; burst[2] = 8'h1C;
    rx_base = rx_cnt;
    done_base = done_cnt;
    n_acc = 0;
    tx_valid = 1'b1;
    tx_data  = burst[0];
    for (int k = 0; k < 2000 && n_acc < 3; k++) begin
      r = tx_ready;
      @(posedge clk);
      #1;
      if (r) begin
        exp_q.push_back(int'(burst[n_acc]));
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) tx_data = burst[n_acc];
      end
    end
    tx_valid = 1'b0;
    check("t3_accepted", n_acc, 3);
    wait_idle(1000);
    check("t3_rx_count", rx_cnt - rx_base, 3);
    check("t3_done_count", done_cnt - done_base, 3);
`ifdef PS2_TX_FIFO_EN
    check("t3_fifo_accept_span", acc_cyc[2] - acc_cyc[0], 2);
`else
    check("t3_hold_accept1", acc_cyc[1], done_cyc_q[done_base] + 1);
    check("t3_hold_accept2", acc_cyc[2], done_cyc_q[done_base + 1] + 1);
`endif
    g = gap_q.size();
    check("t3_gap_a", gap_q[g - 2], IDLE_GAP);
    check("t3_gap_b", gap_q[g - 1], IDLE_GAP);

    // 4: inhibit during bit 5 aborts, then the whole byte is resent once
    rx_base = rx_cnt;
    done_base = done_cnt;
    send_one(8'h32, s);
    repeat (2 * HALF_PER * 5 + HALF_PER + 1) @(posedge clk);
    #1;
    check("t4_clk_low_before", int'(ps2_clk), 0);
    inhibit = 1'b1;
    @(posedge clk);
    #1;
    check("t4_abort_clk", int'(ps2_clk), 1);
    check("t4_abort_data", int'(ps2_data), 1);
    repeat (19) @(posedge clk);
    #1;
    check("t4_no_done", done_cnt - done_base, 0);
    check("t4_no_rx", rx_cnt - rx_base, 0);
    inhibit = 1'b0;
    wait_done(300, d);
    wait_idle(100);
    check("t4_rx_count", rx_cnt - rx_base, 1);
    check("t4_done_count", done_cnt - done_base, 1);

    // 5: inhibit during the stop bit is ignored
    rx_base = rx_cnt;
    done_base = done_cnt;
    send_one(8'($urandom), s);
    repeat (2 * HALF_PER * 10 + 2) @(posedge clk);
    #1;
    inhibit = 1'b1;
    wait_done(50, d);
    check("t5_done_latency", d - s, FRAME_CYC);
    repeat (20) @(posedge clk);
    #1;
    inhibit = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t5_rx_count", rx_cnt - rx_base, 1);
    check("t5_done_count", done_cnt - done_base, 1);
    check("t5_idle", int'(busy), 0);

    // 6: reset during bit 3 drops the frame
    rx_base = rx_cnt;
    send_one(8'($urandom), s);
    repeat (2 * HALF_PER * 3 + 1) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("t6_ps2_clk", int'(ps2_clk), 1);
    check("t6_ps2_data", int'(ps2_data), 1);
    check("t6_busy", int'(busy), 0);
    check("t6_tx_ready", int'(tx_ready), 1);
    reset = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("t6_no_rx", rx_cnt - rx_base, 0);
    check("t6_still_idle", int'(busy), 0);

    // random bytes, random valid pattern, sparse inhibit pulses
    for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
    rx_base = rx_cnt;
    done_base = done_cnt;
    n_acc = 0;
    for (int k = 0; k < 20000 && n_acc < 8; k++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = rb[n_acc];
      inhibit  = ($urandom_range(0, 999) < 3);
      r = tx_valid & tx_ready;
      @(posedge clk);
      #1;
      if (r) begin
        exp_q.push_back(int'(rb[n_acc]));
        n_acc++;
      end
    end
    tx_valid = 1'b0;
    inhibit  = 1'b0;
    check("rnd_accepted", n_acc, 8);
    wait_idle(20000);
    check("rnd_rx_count", rx_cnt - rx_base, 8);
    check("rnd_done_count", done_cnt - done_base, 8);
    check("rnd_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
